hazard_sb: RTL and testbench

Next-generation hazard unit for the 5-stage RV32 pipeline, sitting beside the datapath and driving all stall, flush and forward controls. It keeps the register-forwarding and load-use detection of the single-cycle-EX design and adds a register scoreboard plus a busy counter for a multi-cycle mul/div unit launched from E. It also gives branch flushes priority over stalls and suppresses x0 false hazards.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/md_scoreboard.sv | 90 +++++++++
 rtl/hazard_sb.sv | 124 ++++++++++++
 tb/tb_hazard_sb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: constants shared by the hazard unit and its mul/div scoreboard.
//   FWD_RF / FWD_W / FWD_M : ALU operand select codes (register file, W, M).
//   DEF_REG_ADDR_W         : default register index width (RV32 -> 5).
//   MD_CNT_W               : width of the mul/div busy counter.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int MD_CNT_W       = 4;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/md_scoreboard.sv
// md_scoreboard: busy counter, per-register pending-write bits, in-flight
// destination and illegal-launch flag for the multi-cycle mul/div unit that
// is launched from E. It also produces the D-stage lookups against that state.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   md_start_e, rd_e         : launch request from E and its destination
//   rs1_d, rs2_d, rd_d       : D-stage registers to look up
//   reg_write_d, md_op_d     : D-stage writes rd_d / is itself a mul/div
//   sb_hz                    : D-stage RAW/WAW against a pending mul/div result
//   st_hz                    : D-stage mul/div cannot get the unit
//   md_busy, md_done, md_rd  : unit occupied / result-ready pulse / destination
//   md_err                   : sticky, set by a launch while md_cnt > 1
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_REGS   = 32,
  parameter int MD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  md_start_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  reg_write_d,
  input  logic                  md_op_d,
  output logic                  sb_hz,
  output logic                  st_hz,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [REG_ADDR_W-1:0] md_rd,
  output logic                  md_err
);

  localparam logic [MD_CNT_W-1:0] MD_LAT = MD_CNT_W'(MD_LATENCY);

  logic [MD_CNT_W-1:0] md_cnt;
  logic [NUM_REGS-1:0] sb_q, sb_next;
  logic                cnt_gt1, launch_ok, launch_bad, rd_e_nz;
  logic                hit_pend, hit_same;

  assign rd_e_nz    = rd_e != '0;
  assign cnt_gt1    = md_cnt > MD_CNT_W'(1);
  // A launch in the done cycle is fine: the old result writes back while the
  // new one starts. Anything earlier would clobber the running operation.
  assign launch_ok  = md_start_e & ~cnt_gt1;
  assign launch_bad = md_start_e &  cnt_gt1;

  assign md_busy = md_cnt != '0;
  assign md_done = md_cnt == MD_CNT_W'(1);

  // Clear the finishing destination before setting the new one so that a
  // back-to-back launch to the same register keeps its bit.
  always_comb begin
    sb_next = sb_q;
    if (md_done)              sb_next[md_rd] = 1'b0;
    if (launch_ok && rd_e_nz) sb_next[rd_e]  = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= '0;
      sb_q   <= '0;
      md_rd  <= '0;
      md_err <= 1'b0;
    end else begin
      sb_q <= sb_next;
      if (launch_ok)    md_cnt <= MD_LAT;
      else if (md_busy) md_cnt <= md_cnt - MD_CNT_W'(1);
      // rd_e==0 launches load md_rd too; the done-cycle clear then hits bit 0,
      // which is a no-op.
      if (launch_ok)  md_rd  <= rd_e;
      if (launch_bad) md_err <= 1'b1;
    end
  end

  // Pending result already in the scoreboard.
  assign hit_pend = sb_q[rs1_d] | sb_q[rs2_d] | (reg_write_d & sb_q[rd_d]);
  // Launch happening this very cycle: its bit is not visible until next cycle.
  assign hit_same = md_start_e & rd_e_nz &
                    ((rs1_d == rd_e) | (rs2_d == rd_e) | (reg_write_d & (rd_d == rd_e)));

  assign sb_hz = hit_pend | hit_same;
  assign st_hz = md_op_d & (md_start_e | cnt_gt1);

endmodule

// File: rtl/hazard_sb.sv
// hazard_sb: hazard unit for the 5-stage RV32 pipeline. Drives stall, flush
// and forward controls; tracks the multi-cycle mul/div unit through
// md_scoreboard. All control outputs are combinational from inputs and state.
//
// Ports
//   clk, rst                        : clock, synchronous active-high reset
//   rs1_d, rs2_d, rd_d, reg_write_d : D-stage operands / writer
//   md_op_d                         : D-stage instruction is mul/div
//   rs1_e, rs2_e, rd_e              : E-stage registers
//   pc_src_e                        : taken branch/jump resolved in E
//   res_src_e_b0                    : E-stage instruction is a load
//   md_start_e                      : mul/div launched from E
//   rd_m/reg_write_m, rd_w/reg_write_w : M and W writers
//   stall_f, stall_d, flush_d, flush_e : pipeline register controls
//   forward_a_e, forward_b_e        : ALU operand selects (FWD_* codes)
//   md_busy, md_done, md_rd, md_err : mul/div status
//   perf_stall_cnt, perf_flush_cnt  : wrapping event counters, only when
//                                     HAZARD_PERF_EN is defined
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_REGS   = 32,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  reg_write_d,
  input  logic                  md_op_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  pc_src_e,
  input  logic                  res_src_e_b0,
  input  logic                  md_start_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [REG_ADDR_W-1:0] md_rd,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt,
`endif
  output logic                  md_err
);

  logic lu, sb_hz, st_hz, hold;

  // ---- forwarding: one identical selector per ALU operand, M beats W ----
  logic [1:0][REG_ADDR_W-1:0] rs_e;
  logic [1:0][1:0]            fwd;

  assign rs_e = {rs2_e, rs1_e};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    assign fwd[g] = (rs_e[g] != '0 && reg_write_m && rs_e[g] == rd_m) ? FWD_M :
                    (rs_e[g] != '0 && reg_write_w && rs_e[g] == rd_w) ? FWD_W :
                                                                        FWD_RF;
  end

  assign forward_a_e = fwd[0];
  assign forward_b_e = fwd[1];

  // ---- load-use ----
  assign lu = res_src_e_b0 & (rd_e != '0) & ((rs1_d == rd_e) | (rs2_d == rd_e));

  // ---- mul/div state ----
  md_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS),
    .MD_LATENCY (MD_LATENCY)
  ) u_md_sb (
    .clk         (clk),
    .rst         (rst),
    .md_start_e  (md_start_e),
    .rd_e        (rd_e),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd_d        (rd_d),
    .reg_write_d (reg_write_d),
    .md_op_d     (md_op_d),
    .sb_hz       (sb_hz),
    .st_hz       (st_hz),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_rd       (md_rd),
    .md_err      (md_err)
  );

  // ---- stall / flush ----
  // A taken branch makes the D instruction wrong-path, so it is flushed
  // rather than held.
  assign hold    = lu | sb_hz | st_hz;
  assign stall_f = hold & ~pc_src_e;
  assign stall_d = hold & ~pc_src_e;
  assign flush_d = pc_src_e;
  assign flush_e = pc_src_e | hold;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_d)  perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (pc_src_e) perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// tb_hazard_sb: directed vectors with hand-computed expectations for
// hazard_sb at default parameters (MD_LATENCY=4).
module tb_hazard_sb;
  import hazard_pkg::*;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          reg_write_d, md_op_d, pc_src_e, res_src_e_b0, md_start_e;
  logic          reg_write_m, reg_write_w;
  logic          stall_f, stall_d, flush_d, flush_e, md_busy, md_done, md_err;
  logic [1:0]    forward_a_e, forward_b_e;
  logic [AW-1:0] md_rd;
`ifdef HAZARD_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_flush_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_sb dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_d         (rd_d),
    .reg_write_d  (reg_write_d),
    .md_op_d      (md_op_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .pc_src_e     (pc_src_e),
    .res_src_e_b0 (res_src_e_b0),
    .md_start_e   (md_start_e),
    .rd_m         (rd_m),
    .reg_write_m  (reg_write_m),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .md_rd        (md_rd),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .md_err       (md_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled a
  // further #1 later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_d = '0; rs2_d = '0; rd_d = '0; reg_write_d = 0; md_op_d = 0;
    rs1_e = '0; rs2_e = '0; rd_e = '0; pc_src_e = 0; res_src_e_b0 = 0;
    md_start_e = 0; rd_m = '0; reg_write_m = 0; rd_w = '0; reg_write_w = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    // ---- reset state ----
    chk("rst_busy",  md_busy, 0);
    chk("rst_done",  md_done, 0);
    chk("rst_err",   md_err,  0);
    chk("rst_md_rd", md_rd,   0);
    chk("rst_stall", stall_d, 0);
    chk("rst_flush", flush_e, 0);

    // ---- forwarding ----
    rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; #1;
    chk("fwd_a_m_over_w", forward_a_e, FWD_M);
    reg_write_m = 0; #1;
    chk("fwd_a_w", forward_a_e, FWD_W);
    rs1_e = 0; rd_m = 0; reg_write_m = 1; rd_w = 0; #1;
    chk("fwd_a_x0", forward_a_e, FWD_RF);
    rs2_e = 6; rd_w = 6; rd_m = 3; #1;
    chk("fwd_b_w", forward_b_e, FWD_W);
    reg_write_w = 0; #1;
    chk("fwd_b_none", forward_b_e, FWD_RF);
    clr(); tick();

    // ---- load-use ----
    res_src_e_b0 = 1; rd_e = 7; rs2_d = 7; #1;
    chk("lu_stall_f", stall_f, 1);
    chk("lu_stall_d", stall_d, 1);
    chk("lu_flush_e", flush_e, 1);
    chk("lu_flush_d", flush_d, 0);
    tick();
    res_src_e_b0 = 0; rd_e = 0; #1;
    chk("lu_next_cycle", stall_d, 0);
    res_src_e_b0 = 1; rd_e = 0; rs2_d = 0; #1;
    chk("lu_x0_stall", stall_d, 0);
    chk("lu_x0_flush", flush_e, 0);
    clr(); tick();

    // ---- mul/div dependency: launch rd=9, rs1_d=9 held ----
    md_start_e = 1; rd_e = 9; rs1_d = 9; #1;
    chk("dep_c0_stall", stall_d, 1);
    chk("dep_c0_busy",  md_busy, 0);
    tick();
    md_start_e = 0; rd_e = 0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("dep_c%0d_stall", c), stall_d, 32'(c <= 4));
      chk($sformatf("dep_c%0d_busy",  c), md_busy, 32'(c <= 4));
      chk($sformatf("dep_c%0d_done",  c), md_done, 32'(c == 4));
      if (c == 1) chk("dep_md_rd", md_rd, 9);
      tick();
    end
    clr();

    // ---- back-to-back mul/div ----
    md_start_e = 1; rd_e = 3; tick();
    md_start_e = 0; rd_e = 0;
    for (int c = 1; c <= 3; c++) begin
      md_op_d = 1; #1;
      chk($sformatf("b2b_c%0d_struct", c), stall_d, 1);
      tick();
    end
    md_op_d = 1; md_start_e = 1; rd_e = 4; #1;
    chk("b2b_c4_op_and_start", stall_d, 1);
    chk("b2b_c4_done", md_done, 1);
    md_op_d = 0; #1;
    chk("b2b_c4_nostall", stall_d, 0);
    tick();
    md_start_e = 0; rd_e = 0; #1;
    chk("b2b_c5_err",   md_err,  0);
    chk("b2b_c5_busy",  md_busy, 1);
    chk("b2b_c5_md_rd", md_rd,   4);
    chk("b2b_c5_done",  md_done, 0);
    rs1_d = 3; #1;
    chk("b2b_old_bit_clr", stall_d, 0);
    rs1_d = 0; rs2_d = 4; #1;
    chk("b2b_new_bit_set", stall_d, 1);
    rs2_d = 0;
    repeat (4) tick();
    #1;
    chk("b2b_c9_idle", md_busy, 0);
    clr();

    // ---- illegal launch ----
    md_start_e = 1; rd_e = 11; tick();       // cycle 1
    md_start_e = 0; rd_e = 0; tick();        // cycle 2
    md_start_e = 1; rd_e = 12; tick();       // cycle 3
    md_start_e = 0; rd_e = 0; #1;
    chk("ill_err",   md_err, 1);
    chk("ill_md_rd", md_rd,  11);
    chk("ill_done3", md_done, 0);
    rs1_d = 12; #1;
    chk("ill_no_bit", stall_d, 0);
    rs1_d = 11; #1;
    chk("ill_orig_bit", stall_d, 1);
    rs1_d = 0;
    tick(); #1;                              // cycle 4
    chk("ill_done4",    md_done, 1);
    chk("ill_done4_rd", md_rd,   11);
    tick(); #1;                              // cycle 5
    chk("ill_c5_busy", md_busy, 0);
    chk("ill_sticky",  md_err,  1);
    rst = 1; tick(); rst = 0; #1;
    chk("ill_rst_clr", md_err, 0);

    // ---- branch beats stall, WAW ----
    md_start_e = 1; rd_e = 13; tick();
    md_start_e = 0; rd_e = 0;
    rs1_d = 13; pc_src_e = 1; #1;
    chk("pri_stall_d", stall_d, 0);
    chk("pri_stall_f", stall_f, 0);
    chk("pri_flush_d", flush_d, 1);
    chk("pri_flush_e", flush_e, 1);
    pc_src_e = 0; #1;
    chk("pri_sb_stall", stall_d, 1);
    rs1_d = 0; rd_d = 13; reg_write_d = 1; #1;
    chk("waw_stall", stall_d, 1);
    reg_write_d = 0; #1;
    chk("waw_nowrite", stall_d, 0);
    clr();
    repeat (5) tick();

    // ---- reset mid-operation ----
    md_start_e = 1; rd_e = 14; tick();       // cycle 1
    md_start_e = 0; rd_e = 0; tick();        // cycle 2
    rst = 1; tick();                         // cycle 3
    rst = 0; rs1_d = 14; #1;
    chk("rst_mid_busy",  md_busy, 0);
    chk("rst_mid_sb",    stall_d, 0);
    for (int c = 3; c <= 7; c++) begin
      #1;
      chk($sformatf("rst_mid_done_c%0d", c), md_done, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
